// File: rtl/AXI_package.sv
// Shared definitions for the CICERO AXI register block and its program loader.
// The register block consumes REG_WIDTH-wide command/address/data registers;
// the loader drives them through the command codes defined here.
package AXI_package;

    localparam int REG_WIDTH = 32;

    // Command codes understood by the register block.
    localparam logic [REG_WIDTH-1:0] CMD_NOP   = 32'd0;
    localparam logic [REG_WIDTH-1:0] CMD_WRITE = 32'd1;

    // Program loader sequencing states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        FLUSH = 2'd2
    } loader_state_t;

endpackage

// File: rtl/cicero_loader.sv
// cicero_loader: turns a valid/ready stream of 32-bit instruction words into
// single-cycle CMD_WRITE commands for the CICERO register block, starting at
// base_addr_i for length_i words. A load that would run past the top of the
// BRAM is refused and flagged on error_o.
//
// Optional build macro: CICERO_LOADER_CHECKSUM_EN adds checksum_o, the
// modulo-2^32 sum of the words accepted by the current/most recent load.
//
// Handshake: a word transfers on a rising clk edge where valid_i && ready_o.
// ready_o depends only on the FSM state (high in LOAD), never on valid_i;
// valid_i outside LOAD is ignored.
module cicero_loader
    import AXI_package::*;
#(
    parameter int REG_WIDTH  = AXI_package::REG_WIDTH,
    parameter int ADDR_WIDTH = 11,
    parameter int LEN_WIDTH  = 12
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start_i,
    input  logic [ADDR_WIDTH-1:0] base_addr_i,
    input  logic [LEN_WIDTH-1:0]  length_i,
    input  logic [31:0]           data_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    output logic [REG_WIDTH-1:0]  address_register,
    output logic [REG_WIDTH-1:0]  data_in_register,
    output logic [REG_WIDTH-1:0]  cmd_register,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  error_o,
`ifdef CICERO_LOADER_CHECKSUM_EN
    output logic [31:0]           checksum_o,
`endif
    output loader_state_t         state_dbg
);

    // The range check is done one bit wider than the length so that
    // base + length can express exactly 2^ADDR_WIDTH (a load ending on the
    // last BRAM word) without overflow.
    localparam int SUM_W = LEN_WIDTH + 1;
    localparam logic [SUM_W-1:0] DEPTH = SUM_W'(2 ** ADDR_WIDTH);

    loader_state_t         state_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [LEN_WIDTH-1:0]  remain_q;
    logic [SUM_W-1:0]      end_addr;
    logic                  range_ok;
    logic                  handshake;

    assign end_addr  = SUM_W'(base_addr_i) + SUM_W'(length_i);
    assign range_ok  = (end_addr <= DEPTH);
    assign ready_o   = (state_q == LOAD);
    assign busy_o    = (state_q != IDLE);
    assign done_o    = (state_q == FLUSH);
    assign handshake = valid_i && ready_o;
    assign state_dbg = state_q;

    // Sequencing: accept/refuse start, count words through LOAD, one FLUSH cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            remain_q <= '0;
            error_o  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        if (range_ok) begin
                            addr_q   <= base_addr_i;
                            remain_q <= length_i;
                            error_o  <= 1'b0;
                            // An empty load still reports completion.
                            state_q  <= (length_i == '0) ? FLUSH : LOAD;
                        end else begin
                            error_o  <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (handshake) begin
                        addr_q   <= addr_q + ADDR_WIDTH'(1);
                        remain_q <= remain_q - LEN_WIDTH'(1);
                        if (remain_q == LEN_WIDTH'(1)) begin
                            state_q <= FLUSH;
                        end
                    end
                end
                FLUSH: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Register-block drive: a write triple only in the cycle after a
    // handshake, NOP otherwise, so a stalled stream never repeats a write.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            address_register <= '0;
            data_in_register <= '0;
            cmd_register     <= REG_WIDTH'(CMD_NOP);
        end else if (handshake) begin
            address_register <= REG_WIDTH'(addr_q);
            data_in_register <= REG_WIDTH'(data_i);
            cmd_register     <= REG_WIDTH'(CMD_WRITE);
        end else begin
            cmd_register     <= REG_WIDTH'(CMD_NOP);
        end
    end

`ifdef CICERO_LOADER_CHECKSUM_EN
    logic accept_start;
    assign accept_start = (state_q == IDLE) && start_i && range_ok;

    // Running sum of accepted words; held after completion until next start.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            checksum_o <= '0;
        end else if (accept_start) begin
            checksum_o <= '0;
        end else if (handshake) begin
            checksum_o <= checksum_o + data_i;
        end
    end
`endif

endmodule

// File: tb/tb_cicero_loader.sv
// Bench for cicero_loader: directed scenarios plus randomized loads, with a
// scoreboard of expected register-block writes and a small BRAM model.
module tb_cicero_loader;
    import AXI_package::*;

    localparam int AW = 11;
    localparam int LW = 12;
    localparam int RW = 32;
    localparam int EW = AW + 32;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic          start_i     = 1'b0;
    logic [AW-1:0] base_addr_i = '0;
    logic [LW-1:0] length_i    = '0;
    logic [31:0]   data_i      = '0;
    logic          valid_i     = 1'b0;
    logic          ready_o;
    logic [RW-1:0] address_register;
    logic [RW-1:0] data_in_register;
    logic [RW-1:0] cmd_register;
    logic          busy_o;
    logic          done_o;
    logic          error_o;
    loader_state_t state_dbg;
`ifdef CICERO_LOADER_CHECKSUM_EN
    logic [31:0]   checksum_o;
`endif

    cicero_loader #(
        .REG_WIDTH (RW),
        .ADDR_WIDTH(AW),
        .LEN_WIDTH (LW)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .start_i         (start_i),
        .base_addr_i     (base_addr_i),
        .length_i        (length_i),
        .data_i          (data_i),
        .valid_i         (valid_i),
        .ready_o         (ready_o),
        .address_register(address_register),
        .data_in_register(data_in_register),
        .cmd_register    (cmd_register),
        .busy_o          (busy_o),
        .done_o          (done_o),
        .error_o         (error_o),
`ifdef CICERO_LOADER_CHECKSUM_EN
        .checksum_o      (checksum_o),
`endif
        .state_dbg       (state_dbg)
    );

    // ---------------- bookkeeping ----------------
    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int n_writes = 0;
    int n_done = 0;
    int last_done_cyc = -1;
    int write_cyc[$];
    int start_cyc = 0;
    int wc0 = 0;
    logic [31:0] last_cks = '0;
    logic [31:0] mem [0:(1<<AW)-1];

    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] exp_e;
    logic [31:0]   word_q[$];
    int            gap_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard monitor ----------------
    // Every cycle out of reset: the command must be NOP or WRITE, and each
    // WRITE must match the oldest expected (address, word) pair.
    always @(negedge clk) begin
        if (reset) begin
            if (done_o === 1'b1) begin
                n_done++;
                last_done_cyc = cyc;
            end
            n_cmp++;
            if (cmd_register === CMD_WRITE) begin
                n_writes++;
                write_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_write: got addr=%h data=%h, required no write",
                             address_register, data_in_register);
                end else begin
                    exp_e = exp_q.pop_front();
                    if (address_register !== RW'(exp_e[EW-1:32]) || data_in_register !== exp_e[31:0]) begin
                        n_bad++;
                        $display("FAIL write_triple: got addr=%h data=%h, required addr=%h data=%h",
                                 address_register, data_in_register, RW'(exp_e[EW-1:32]), exp_e[31:0]);
                    end
                    mem[address_register[AW-1:0]] = data_in_register;
                end
            end else if (cmd_register !== CMD_NOP) begin
                n_bad++;
                $display("FAIL cmd_value: got %h, required NOP or WRITE", cmd_register);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send_word(input logic [31:0] w, output bit hs);
        int budget;
        valid_i = 1'b1;
        data_i  = w;
        hs      = 1'b0;
        budget  = 0;
        while (!hs && budget < 20) begin
            @(negedge clk);
            hs = (ready_o === 1'b1);
            @(posedge clk);
            #1;
            budget++;
        end
        n_cmp++;
        if (!hs) begin
            n_bad++;
            $display("FAIL handshake_timeout: got no ready in 20 cycles, required ready");
        end
    endtask

    // One complete load through the reference rules: accepted iff
    // base + len <= 2^AW; each word i lands at base + i.
    task automatic run_load(input int base, input int len);
        bit          ok;
        bit          hs;
        int          wr0;
        int          dn0;
        int          budget;
        logic [31:0] sum;
        ok  = (base + len) <= (1 << AW);
        sum = '0;
        if (ok) begin
            for (int i = 0; i < len; i++) begin
                exp_q.push_back({AW'(base + i), word_q[i]});
                sum = sum + word_q[i];
            end
        end
        wr0 = n_writes;
        dn0 = n_done;
        wc0 = write_cyc.size();
        @(posedge clk);
        #1;
        start_i     = 1'b1;
        base_addr_i = AW'(base);
        length_i    = LW'(len);
        @(posedge clk);
        #1;
        start_i     = 1'b0;
        base_addr_i = AW'($urandom);
        length_i    = LW'($urandom);
        start_cyc   = cyc;
        n_cmp++;
        if (error_o !== !ok) begin
            n_bad++;
            $display("FAIL error_flag: got %b, required %b (base=%0d len=%0d)", error_o, !ok, base, len);
        end
        n_cmp++;
        if (busy_o !== ok) begin
            n_bad++;
            $display("FAIL busy_after_start: got %b, required %b", busy_o, ok);
        end
        if (!ok) begin
            repeat (3) @(posedge clk);
            #1;
            n_cmp++;
            if (n_writes != wr0 || busy_o !== 1'b0) begin
                n_bad++;
                $display("FAIL refused_load: got writes=%0d busy=%b, required writes=0 busy=0",
                         n_writes - wr0, busy_o);
            end
            return;
        end
        for (int i = 0; i < len; i++) begin
            if (gap_q[i] > 0) begin
                valid_i = 1'b0;
                data_i  = $urandom;
                repeat (gap_q[i]) begin
                    @(posedge clk);
                    #1;
                end
            end
            send_word(word_q[i], hs);
        end
        // A stray valid after the last word must not be accepted.
        valid_i = 1'($urandom_range(0, 1));
        data_i  = $urandom;
        budget  = 0;
        while (budget < 20) begin
            @(negedge clk);
            if (done_o === 1'b1) break;
            budget++;
        end
`ifdef CICERO_LOADER_CHECKSUM_EN
        last_cks = checksum_o;
        n_cmp++;
        if (checksum_o !== sum) begin
            n_bad++;
            $display("FAIL checksum: got %h, required %h", checksum_o, sum);
        end
`endif
        n_cmp++;
        if (budget >= 20) begin
            n_bad++;
            $display("FAIL done_timeout: got no done in 20 cycles, required done");
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if (busy_o !== 1'b0) begin
            n_bad++;
            $display("FAIL busy_after_done: got %b, required 0", busy_o);
        end
        @(posedge clk);
        #1;
        valid_i = 1'b0;
        @(posedge clk);
        #1;
        n_cmp++;
        if (n_writes - wr0 != len || n_done - dn0 != 1 || exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL load_totals: got writes=%0d done=%0d pending=%0d, required writes=%0d done=1 pending=0",
                     n_writes - wr0, n_done - dn0, exp_q.size(), len);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        #1;
        n_cmp++;
        if (cmd_register !== CMD_NOP || address_register !== '0 || data_in_register !== '0) begin
            n_bad++;
            $display("FAIL reset_regs: got cmd=%h addr=%h data=%h, required %h/0/0",
                     cmd_register, address_register, data_in_register, CMD_NOP);
        end
        n_cmp++;
        if (ready_o !== 1'b0 || busy_o !== 1'b0 || done_o !== 1'b0 || error_o !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_flags: got ready=%b busy=%b done=%b error=%b, required all 0",
                     ready_o, busy_o, done_o, error_o);
        end
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b1;
    endtask

    task automatic test_basic_load;
        word_q = '{32'hDEADBEEF, 32'h01234567, 32'hCAFEF00D};
        gap_q  = '{0, 0, 0};
        run_load(32'h010, 3);
        n_cmp++;
        if (write_cyc.size() < wc0 + 3 || write_cyc[wc0] != start_cyc + 1 ||
            write_cyc[wc0+1] != start_cyc + 2 || write_cyc[wc0+2] != start_cyc + 3) begin
            n_bad++;
            $display("FAIL basic_write_timing: got first write at cycle offset %0d, required 1,2,3",
                     (write_cyc.size() > wc0) ? write_cyc[wc0] - start_cyc : -1);
        end
        n_cmp++;
        if (last_done_cyc != start_cyc + 3) begin
            n_bad++;
            $display("FAIL basic_done_timing: got offset %0d, required 3", last_done_cyc - start_cyc);
        end
        n_cmp++;
        if (mem[11'h011][15:0] !== 16'h4567) begin
            n_bad++;
            $display("FAIL bram_read_0x011: got %h, required 4567", mem[11'h011][15:0]);
        end
    endtask

    task automatic test_stall;
        word_q = '{32'hDEADBEEF, 32'h01234567, 32'hCAFEF00D};
        gap_q  = '{0, 0, 2};
        run_load(32'h010, 3);
        n_cmp++;
        if (write_cyc.size() < wc0 + 3 || write_cyc[wc0+2] - write_cyc[wc0+1] != 3) begin
            n_bad++;
            $display("FAIL stall_gap: got spacing %0d, required 3",
                     (write_cyc.size() >= wc0 + 3) ? write_cyc[wc0+2] - write_cyc[wc0+1] : -1);
        end
    endtask

    task automatic test_range_error;
        word_q = '{32'h11111111, 32'h22222222, 32'h33333333};
        gap_q  = '{0, 0, 0};
        run_load(32'h7FE, 3);
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (error_o !== 1'b1) begin
            n_bad++;
            $display("FAIL error_sticky: got %b, required 1", error_o);
        end
        // Exactly reaches the top word: accepted, clears the error.
        run_load(32'h7FD, 3);
        n_cmp++;
        if (mem[11'h7FF] !== 32'h33333333) begin
            n_bad++;
            $display("FAIL top_word: got %h, required 33333333", mem[11'h7FF]);
        end
    endtask

    task automatic test_zero_length;
        word_q.delete();
        gap_q.delete();
        run_load(0, 0);
        n_cmp++;
        if (last_done_cyc != start_cyc) begin
            n_bad++;
            $display("FAIL zero_len_done: got offset %0d, required 0", last_done_cyc - start_cyc);
        end
    endtask

    task automatic test_reset_mid_load;
        bit hs;
        int wr0;
        wr0 = n_writes;
        for (int i = 0; i < 2; i++) begin
            word_q[i] = $urandom;
        end
        exp_q.push_back({AW'(32'h100), word_q[0]});
        exp_q.push_back({AW'(32'h101), word_q[1]});
        @(posedge clk);
        #1;
        start_i     = 1'b1;
        base_addr_i = AW'(32'h100);
        length_i    = LW'(5);
        @(posedge clk);
        #1;
        start_i = 1'b0;
        send_word(word_q[0], hs);
        send_word(word_q[1], hs);
        valid_i = 1'b1;
        data_i  = $urandom;
        @(negedge clk);
        #1;
        reset = 1'b0;
        #1;
        n_cmp++;
        if (cmd_register !== CMD_NOP || address_register !== '0 || data_in_register !== '0) begin
            n_bad++;
            $display("FAIL async_reset_regs: got cmd=%h addr=%h data=%h, required NOP/0/0",
                     cmd_register, address_register, data_in_register);
        end
        n_cmp++;
        if (busy_o !== 1'b0 || ready_o !== 1'b0 || done_o !== 1'b0) begin
            n_bad++;
            $display("FAIL async_reset_flags: got busy=%b ready=%b done=%b, required 0",
                     busy_o, ready_o, done_o);
        end
        valid_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        n_cmp++;
        if (n_writes - wr0 != 2 || exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL writes_before_reset: got %0d pending=%0d, required 2 pending=0",
                     n_writes - wr0, exp_q.size());
        end
        word_q = '{32'hA5A5A5A5, 32'h5A5A5A5A};
        gap_q  = '{0, 0};
        run_load(32'h100, 2);
    endtask

    task automatic test_checksum;
        word_q = '{32'hFFFFFFFF, 32'h00000002};
        gap_q  = '{0, 1};
        run_load(32'h200, 2);
        n_cmp++;
        if (last_cks !== 32'h00000001) begin
            n_bad++;
            $display("FAIL checksum_wrap: got %h, required 00000001", last_cks);
        end
    endtask

    task automatic test_random_loads;
        int base;
        int len;
        for (int t = 0; t < 12; t++) begin
            len  = $urandom_range(0, 6);
            base = ($urandom_range(0, 1) == 1) ? $urandom_range(2040, 2047) : $urandom_range(0, 2047);
            word_q.delete();
            gap_q.delete();
            for (int i = 0; i < len; i++) begin
                word_q.push_back($urandom);
                gap_q.push_back($urandom_range(0, 2));
            end
            run_load(base, len);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_basic_load();
        test_stall();
        test_range_error();
        test_zero_length();
        test_reset_mid_load();
`ifdef CICERO_LOADER_CHECKSUM_EN
        test_checksum();
`endif
        test_random_loads();
        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got no completion, required completion");
        $fatal(1, "bench timeout");
    end

endmodule

// File: doc/cicero_loader.md
# cicero_loader

Upstream program loader for the CICERO AXI register block. It accepts a valid/ready stream of 32-bit instruction words plus a start address and word count. It then drives the register block's `address_register`, `data_in_register` and `cmd_register` inputs so that each accepted word becomes exactly one single-cycle `CMD_WRITE`. It returns the command to `CMD_NOP` whenever no write is due, and reports completion or a range error.

## Interface
Parameters:
- `REG_WIDTH`, 32: register width; must match the register block.
- `ADDR_WIDTH`, 11: BRAM word-address width; memory depth is 2^ADDR_WIDTH.
- `LEN_WIDTH`, 12: width of the word-count input.

Ports:
- `clk`  in  1  single clock
- `reset`  in  1  asynchronous, active-low reset
- `start_i`  in  1  one-cycle load request
- `base_addr_i`  in  ADDR_WIDTH  first BRAM address
- `length_i`  in  LEN_WIDTH  number of words to load
- `data_i`  in  32  stream word
- `valid_i`  in  1  stream word valid
- `ready_o`  out  1  loader accepts the word
- `address_register`  out  REG_WIDTH  to register block; zero-extended address
- `data_in_register`  out  REG_WIDTH  to register block
- `cmd_register`  out  REG_WIDTH  to register block
- `busy_o`  out  1  load in progress
- `done_o`  out  1  one-cycle completion pulse
- `error_o`  out  1  sticky range error; cleared by the next accepted start

## Operation
- State machine states: IDLE, LOAD, FLUSH.
- IDLE:
  - `start_i` high with `base_addr_i + length_i <= 2^ADDR_WIDTH` (computed at LEN_WIDTH+1 bits): latch the address counter and remaining-count, clear `error_o`, go to LOAD.
  - `length_i == 0`: go straight to FLUSH.
  - Range violation: set `error_o`, stay in IDLE, write nothing.
- LOAD:
  - `ready_o = 1`.
  - On every `valid_i && ready_o`, register the address counter into `address_register`, `data_i` into `data_in_register`, and `CMD_WRITE` into `cmd_register`. Then increment the address and decrement the remaining-count.
  - Any LOAD cycle without a handshake registers `CMD_NOP`. This guarantees no duplicate write when the stream stalls.
  - The handshake on the last word (remaining == 1) moves the FSM to FLUSH.
- FLUSH:
  - `ready_o = 0`.
  - Registers `CMD_NOP` and pulses `done_o`, then returns to IDLE.
- `start_i` in LOAD or FLUSH is ignored. `valid_i` in IDLE or FLUSH is not accepted.
- The address counter never wraps inside a load because of the start range check. The counter itself is ADDR_WIDTH-bit modulo.
- `busy_o` is high in LOAD and FLUSH.
- Upper bits of `address_register` above ADDR_WIDTH are zero.

## Timing
- Reset value of every output: `cmd_register = CMD_NOP`, and all other outputs are 0.
- Reset mid-load: the FSM returns immediately to IDLE and the command goes to `CMD_NOP`. Words already written are not undone.
- Cycle timing:
  - Start sampled at edge 0: LOAD from cycle 1, `ready_o` high in cycle 1.
  - Handshake at edge k: the `CMD_WRITE` triple is visible during cycle k+1, and the register block writes the BRAM during that cycle.
  - Throughput is 1 word per cycle.
  - Last handshake at edge n: the final write is visible in cycle n+1, which is also FLUSH. `cmd_register` is `CMD_NOP` from cycle n+2, with `done_o` high in cycle n+1. IDLE from cycle n+2.
- `length_i == 0`: `done_o` in cycle 1, with no `CMD_WRITE`.
- `ready_o` is combinational from state only. It never depends on `valid_i`.

## Configuration
- `CICERO_LOADER_CHECKSUM_EN` defined:
  - Adds output `checksum_o` (32 bits).
  - It is cleared at each accepted start, and every accepted word is added modulo 2^32.
  - The value is stable from the `done_o` cycle until the next start.
- Macro undefined: no port and no adder.

## Structure
- Reuse `CMD_NOP`, `CMD_WRITE` and `REG_WIDTH` from `AXI_package`. Do not redefine them.
- Add a `loader_state_t` enum (IDLE, LOAD, FLUSH) to `AXI_package`.
- Single module; no sub-module is warranted.
- The checksum accumulator stays inline under the macro.

## Test plan
- Basic load:
  - Stimulus: base 0x010, length 3, words 0xDEADBEEF, 0x01234567, 0xCAFEF00D, `valid_i` held high.
  - Required: `CMD_WRITE` in three consecutive cycles at addresses 0x010, 0x011, 0x012, then `CMD_NOP`. One `done_o` pulse.
  - A read of address 0x011 through the register block returns the low half, 0x4567.
- Stall:
  - Stimulus: same load with `valid_i` low for 2 cycles between word 1 and word 2.
  - Required: `CMD_NOP` in the gap cycles and exactly 3 writes.
- Range error:
  - Stimulus: base 0x7FE, length 3.
  - Required: `error_o` = 1, no `CMD_WRITE`, `busy_o` stays 0.
  - A following valid start clears `error_o`.
- Zero length:
  - Stimulus: base 0x000, length 0.
  - Required: `done_o` in cycle 1 and no writes.
- Reset mid-load:
  - Stimulus: assert `reset` (low) after word 2 of 5.
  - Required: outputs return to reset values, with `CMD_NOP` asynchronously.
  - After release, a new start loads normally.
- Checksum (macro defined):
  - Stimulus: words 0xFFFFFFFF and 0x00000002.
  - Required: `checksum_o` = 0x00000001 at `done_o`.
